// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, flag bit positions and default width.
package alu_pkg;

  // Default datapath width of the ALU and the issue stage.
  localparam int ALU_W = 32;

  localparam logic [3:0] ALU_OR   = 4'd0;
  localparam logic [3:0] ALU_AND  = 4'd1;
  localparam logic [3:0] ALU_NAND = 4'd2;
  localparam logic [3:0] ALU_NOR  = 4'd3;
  localparam logic [3:0] ALU_NOT  = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_ADD  = 4'd6;
  localparam logic [3:0] ALU_SUB  = 4'd7;
  localparam logic [3:0] ALU_SHL  = 4'd8;
  localparam logic [3:0] ALU_SHR  = 4'd9;
  localparam logic [3:0] ALU_CMP  = 4'd10;
  localparam logic [3:0] ALU_LROT = 4'd11;
  localparam logic [3:0] ALU_RROT = 4'd12;

  localparam logic [3:0] ALU_OP_MAX = 4'd12;

  // Bit positions inside res_flags.
  localparam int FLG_CARRY = 0;
  localparam int FLG_NEG   = 1;
  localparam int FLG_ZERO  = 2;
  localparam int FLG_OVF   = 3;
  localparam int FLG_ILL   = 4;

  // True for opcodes above ALU_OP_MAX.
  function automatic logic op_illegal(input logic [3:0] op);
    return op > ALU_OP_MAX;
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO; head is the oldest entry, valid when count != 0.
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 68
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DW-1:0]            wdata,
  output logic [DW-1:0]            head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign head = mem[rd_ptr];
  assign full = (count == DEPTH_C);

  // Storage write; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy bookkeeping; push+pop leaves count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue/retire stage around the combinational ALU: command FIFO in,
// registered result out, plus sticky overflow/carry status.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. cmd_ready depends only on registered occupancy. res_valid, once
// high, holds res_y/res_flags stable until res_ready is seen high.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = ALU_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [3:0]             cmd_op,
  input  logic [W-1:0]           cmd_a,
  input  logic [W-1:0]           cmd_b,
  output logic [W-1:0]           alu_a,
  output logic [W-1:0]           alu_b,
  output logic [3:0]             alu_control,
  input  logic [W-1:0]           alu_y,
  input  logic                   alu_carry,
  input  logic                   alu_neg,
  input  logic                   alu_zero,
  input  logic                   alu_ovf,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [W-1:0]           res_y,
  output logic [4:0]             res_flags,
  input  logic                   sticky_clr,
  output logic [1:0]             sticky,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int DW = 4 + 2 * W;

  logic          push;
  logic          cap;
  logic          full;
  logic          empty;
  logic          head_ill;
  logic [DW-1:0] head;
  logic [3:0]    head_op;
  logic [W-1:0]  head_a;
  logic [W-1:0]  head_b;

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (cap),
    .wdata ({cmd_op, cmd_a, cmd_b}),
    .head  (head),
    .count (fifo_count),
    .full  (full)
  );

  assign {head_op, head_a, head_b} = head;

  assign empty     = (fifo_count == '0);
  assign cmd_ready = ~full;
  assign push      = cmd_valid & cmd_ready;
  // Capture whenever a command is waiting and the output slot is free or draining.
  assign cap       = ~empty & (~res_valid | res_ready);
  assign head_ill  = op_illegal(head_op);

  // Quiet ALU inputs while nothing is queued.
  assign alu_a       = empty ? '0 : head_a;
  assign alu_b       = empty ? '0 : head_b;
  assign alu_control = empty ? 4'd0 : head_op;

  // Output register: load on capture, drop valid when drained with nothing behind it.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_y     <= '0;
      res_flags <= '0;
    end else if (cap) begin
      res_valid <= 1'b1;
      res_y     <= alu_y;
      res_flags <= {head_ill, alu_ovf, alu_zero, alu_neg, alu_carry};
    end else if (res_valid && res_ready) begin
      res_valid <= 1'b0;
    end
  end

  // Sticky status: a legal capture sets bits, clear applies first so set wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky <= 2'b00;
    end else begin
      sticky <= (sticky_clr ? 2'b00 : sticky)
              | ((cap && !head_ill) ? {alu_ovf, alu_carry} : 2'b00);
    end
  end

endmodule
